// File: rtl/key_conditioner.sv
// Turns raw DE2 push-buttons into debounced levels and one-hot command pulses for the menu FSM.
// Define KEY_AUTOREPEAT_EN to add hold-to-repeat on the REPEAT_MASK keys.
module key_conditioner #(
  parameter int                N_KEYS          = 4,
  parameter int                DEBOUNCE_CYCLES = 4096,
  parameter bit                ACTIVE_LOW      = 1'b1,
  parameter int                REPEAT_DELAY    = 65536,
  parameter int                REPEAT_PERIOD   = 16384,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = 4'b0011
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_pulse,
  output logic [N_KEYS-1:0] o_level,
  output logic              o_busy
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] key_pressed;
  logic [N_KEYS-1:0] s1_q;
  logic [N_KEYS-1:0] s2_q;
  logic [N_KEYS-1:0] stable_q;
  logic [N_KEYS-1:0] stable_d;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] repeat_hit;
  logic [N_KEYS-1:0] grant;
  logic [N_KEYS-1:0] pending_q;
  logic [N_KEYS-1:0] pending_d;
  logic [N_KEYS-1:0] pulse_q;
  logic              busy_q;

  // Internally 1 always means pressed, so the reset value 0 is the released level.
  assign key_pressed = ACTIVE_LOW ? ~i_key : i_key;

  // Debounce: the counter only runs while s2 disagrees with the accepted level.
  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < N_KEYS; k++) begin
      cnt_d[k] = '0;
      if (s2_q[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        stable_d[k] = s2_q[k];
        cnt_d[k]    = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  assign press     = stable_d & ~stable_q;
  // Isolate the lowest set pending bit (two's-complement trick).
  assign grant     = pending_q & (~pending_q + N_KEYS'(1));
  assign pending_d = (pending_q & ~grant) | press | repeat_hit;

  // Synchroniser, debounce state, pending queue and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      pending_q <= '0;
      pulse_q   <= '0;
      busy_q    <= 1'b0;
      for (int k = 0; k < N_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      s1_q      <= key_pressed;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      pending_q <= pending_d;
      pulse_q   <= grant;
      busy_q    <= |pending_d;
      for (int k = 0; k < N_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int                HOLD_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [HOLD_W-1:0] hold_q [N_KEYS];
  logic [HOLD_W-1:0] hold_d [N_KEYS];

  // Hold timer counts only while held before and after the edge; reloading it
  // PERIOD short of the threshold spaces later repeats by REPEAT_PERIOD.
  always_comb begin
    repeat_hit = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      hold_d[k] = '0;
      if (REPEAT_MASK[k] && stable_q[k] && stable_d[k]) begin
        if (hold_q[k] == HOLD_LAST) begin
          repeat_hit[k] = 1'b1;
          hold_d[k]     = HOLD_RELOAD;
        end else begin
          hold_d[k] = hold_q[k] + HOLD_W'(1);
        end
      end else begin
        hold_d[k] = '0;
      end
    end
  end

  // Hold timer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < N_KEYS; k++) begin
        hold_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        hold_q[k] <= hold_d[k];
      end
    end
  end
`else
  assign repeat_hit = '0;
`endif

  assign o_pulse = pulse_q;
  assign o_level = stable_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random bouncing keys,
// all compared every cycle against a sample-history reference model.
module tb_key_conditioner;

  localparam int         DB    = 4;
  localparam int         RD    = 20;
  localparam int         RP    = 8;
  localparam logic [3:0] RMASK = 4'b0011;

  logic       i_clk;
  logic       i_rst;
  logic [3:0] i_key;
  logic [3:0] o_pulse;
  logic [3:0] o_level;
  logic       o_busy;

  key_conditioner #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK(RMASK)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_key(i_key),
    .o_pulse(o_pulse),
    .o_level(o_level),
    .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pressed levels sampled at each edge, newest in m_hist[0].
  logic [3:0] pressed;
  logic [3:0] m_hist [8];
  logic [3:0] m_stable;
  logic [3:0] m_pending;
  logic [3:0] m_pulse;
  string      phase;
`ifdef KEY_AUTOREPEAT_EN
  int         m_held [4];
`endif

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_hist[i] = 4'b0000;
    m_stable  = 4'b0000;
    m_pending = 4'b0000;
    m_pulse   = 4'b0000;
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 0; k < 4; k++) m_held[k] = 0;
`endif
  endtask

  // A level is accepted once the DB samples seen through the 2-stage sync all disagree with it.
  task automatic model_edge();
    logic [3:0] old_st;
    logic [3:0] newp;
    logic [3:0] rep;
    logic [3:0] gnt;
    logic       all_diff;
    for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = pressed;
    old_st = m_stable;
    for (int k = 0; k < 4; k++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++) begin
        if (m_hist[j][k] == old_st[k]) all_diff = 1'b0;
      end
      if (all_diff) m_stable[k] = ~old_st[k];
    end
    newp = m_stable & ~old_st;
    rep  = 4'b0000;
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 0; k < 4; k++) begin
      if (RMASK[k] && old_st[k] && m_stable[k]) begin
        m_held[k]++;
        if (m_held[k] >= RD && ((m_held[k] - RD) % RP) == 0) rep[k] = 1'b1;
      end else begin
        m_held[k] = 0;
      end
    end
`endif
    gnt = 4'b0000;
    for (int k = 3; k >= 0; k--) begin
      if (m_pending[k]) gnt = 4'b0001 << k;
    end
    m_pulse   = gnt;
    m_pending = (m_pending & ~gnt) | newp | rep;
  endtask

  task automatic cycle(input logic [3:0] p);
    pressed = p;
    i_key   = ~p;
    @(posedge i_clk);
    if (!i_rst) model_edge();
    #1;
    chk({phase, ":pulse"}, o_pulse, m_pulse);
    chk({phase, ":level"}, o_level, m_stable);
    chk({phase, ":busy"}, {3'b000, o_busy}, {3'b000, |m_pending});
  endtask

  task automatic do_reset(input logic [3:0] p);
    pressed = p;
    i_key   = ~p;
    i_rst   = 1'b1;
    model_clear();
    #1;
    chk({phase, ":rst_pulse"}, o_pulse, 4'b0000);
    chk({phase, ":rst_level"}, o_level, 4'b0000);
    chk({phase, ":rst_busy"}, {3'b000, o_busy}, 4'b0000);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  int         first_a;
  int         first_b;
  int         busy_a;
  int         npulse;
  int         run_left [4];
  logic [3:0] rp;
  int         pq [$];

  initial begin
    phase   = "init";
    pressed = 4'b0000;
    i_key   = 4'hF;
    i_rst   = 1'b0;
    model_clear();
    do_reset(4'b0000);
    repeat (9) cycle(4'b0000);

    // Single press of select, then release.
    phase   = "t1";
    first_a = -1;
    first_b = -1;
    npulse  = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(4'b1000);
      if (o_pulse != 4'b0000) begin
        npulse++;
        if (first_a < 0 && o_pulse == 4'b1000) first_a = i;
      end
      if (o_level[3] && first_b < 0) first_b = i;
    end
    chk_i("t1_pulse_edge", first_a, 6);
    chk_i("t1_level_edge", first_b, 5);
    chk_i("t1_pulse_count", npulse, 1);
    first_a = -1;
    npulse  = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0000);
      if (o_pulse != 4'b0000) npulse++;
      if (!o_level[3] && first_a < 0) first_a = i;
    end
    chk_i("t1_release_edge", first_a, 5);
    chk_i("t1_release_pulses", npulse, 0);

    // Bounce on key 1: runs of 3 never qualify.
    phase  = "t2";
    npulse = 0;
    first_a = 0;
    for (int i = 0; i < 15; i++) begin
      cycle((i < 3 || (i >= 4 && i < 7)) ? 4'b0010 : 4'b0000);
      if (o_pulse != 4'b0000) npulse++;
      if (o_level != 4'b0000) first_a++;
    end
    chk_i("t2_pulses", npulse, 0);
    chk_i("t2_level_cycles", first_a, 0);

    // Keys 0 and 3 together: arbitration order and busy in between.
    phase   = "t3";
    first_a = -1;
    first_b = -1;
    busy_a  = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(4'b1001);
      if (o_pulse == 4'b0001 && first_a < 0) begin
        first_a = i;
        busy_a  = int'(o_busy);
      end
      if (o_pulse == 4'b1000 && first_b < 0) first_b = i;
    end
    chk_i("t3_first_pulse", first_a, 6);
    chk_i("t3_second_pulse", first_b, 7);
    chk_i("t3_busy_between", busy_a, 1);
    repeat (8) cycle(4'b0000);

    // Reset while pending[2] is still queued.
    phase = "t4";
    for (int i = 0; i < 8; i++) cycle(4'b0111);
    chk_i("t4_busy_before", int'(o_busy), 1);
    do_reset(4'b0000);
    npulse = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(4'b0000);
      if (o_pulse != 4'b0000) npulse++;
    end
    chk_i("t4_pulses_after", npulse, 0);

    // Key 2 held through reset deassertion.
    phase = "t5";
    do_reset(4'b0100);
    first_a = -1;
    npulse  = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0100);
      if (o_pulse != 4'b0000) npulse++;
      if (o_pulse == 4'b0100 && first_a < 0) first_a = i;
    end
    chk_i("t5_pulse_edge", first_a, 6);
    chk_i("t5_pulse_count", npulse, 1);
    repeat (8) cycle(4'b0000);

    // Long hold on up (repeat-eligible) and select (not eligible).
    phase = "t6";
    pq.delete();
    for (int i = 0; i < 70; i++) begin
      cycle(i < 60 ? 4'b0010 : 4'b0000);
      if (o_pulse == 4'b0010) pq.push_back(i);
    end
`ifdef KEY_AUTOREPEAT_EN
    chk_i("t6_up_count", pq.size(), 6);
    if (pq.size() >= 3) begin
      chk_i("t6_first", pq[0], 6);
      chk_i("t6_repeat1", pq[1] - pq[0], RD);
      chk_i("t6_repeat2", pq[2] - pq[0], RD + RP);
    end
`else
    chk_i("t6_up_count", pq.size(), 1);
`endif
    npulse = 0;
    for (int i = 0; i < 70; i++) begin
      cycle(i < 60 ? 4'b1000 : 4'b0000);
      if (o_pulse != 4'b0000) npulse++;
    end
    chk_i("t6_select_count", npulse, 1);

    // Random bouncing on all keys.
    phase = "rand";
    rp    = 4'b0000;
    for (int k = 0; k < 4; k++) run_left[k] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (run_left[k] == 0) begin
          rp[k]       = 1'($urandom_range(0, 1));
          run_left[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 30))
                                                    : int'($urandom_range(1, 5));
        end
        run_left[k]--;
      end
      cycle(rp);
    end
    repeat (40) cycle(4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
